// File: rtl/hex_display_bank.sv
// +--------------------------------------------------------------------------+
// | hex_display_bank                                                         |
// | N-digit active-low 7-segment hex driver with static/blink/scroll modes.  |
// | Optional macro LZ_BLANK_EN enables leading-zero blanking.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hex_display_bank #(
   parameter int NUM_DIGITS = 2,
   parameter int TICK_DIV   = 25_000_000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   data,
   input  logic [1:0]                mode,
   input  logic                      enable,
   output logic [7*NUM_DIGITS-1:0]   hex,
   output logic                      tick
);

   localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STATIC = 2'd1,
      ST_BLINK  = 2'd2,
      ST_SCROLL = 2'd3
   } state_t;

   state_t                    r_state;
   logic [c_cnt_w-1:0]        r_cnt;
   logic                      r_phase;
   logic [4*NUM_DIGITS-1:0]   r_digits;
   logic [4*NUM_DIGITS-1:0]   w_rot;
   logic                      w_wrap;
   logic                      w_blank;
   logic [3:0]                w_nib;
`ifdef LZ_BLANK_EN
   logic                      w_lz_run;
`endif

   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      case (d)
         4'h0: f_glyph = 7'h40;
         4'h1: f_glyph = 7'h79;
         4'h2: f_glyph = 7'h24;
         4'h3: f_glyph = 7'h30;
         4'h4: f_glyph = 7'h19;
         4'h5: f_glyph = 7'h12;
         4'h6: f_glyph = 7'h02;
         4'h7: f_glyph = 7'h78;
         4'h8: f_glyph = 7'h00;
         4'h9: f_glyph = 7'h10;
         4'hA: f_glyph = 7'h08;
         4'hB: f_glyph = 7'h03;
         4'hC: f_glyph = 7'h46;
         4'hD: f_glyph = 7'h21;
         4'hE: f_glyph = 7'h06;
         default: f_glyph = 7'h0E;
      endcase
   endfunction

   // Rotate toward the more significant end; top digit wraps into digit 0.
   generate
      if (NUM_DIGITS == 1) begin : g_rot_single
         assign w_rot = r_digits;
      end else begin : g_rot_multi
         assign w_rot = {r_digits[4*NUM_DIGITS-5:0], r_digits[4*NUM_DIGITS-1 -: 4]};
      end
   endgenerate

   assign w_wrap = (r_cnt == c_cnt_w'(TICK_DIV - 1));
   assign tick   = w_wrap && enable && (r_state != ST_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_phase  <= 1'b0;
         r_digits <= '0;
      end else if (load) begin
         r_digits <= data;
         r_cnt    <= '0;
         r_phase  <= 1'b0;
         case (mode)
            2'b01:   r_state <= ST_BLINK;
            2'b10:   r_state <= ST_SCROLL;
            default: r_state <= ST_STATIC;
         endcase
      end else if (enable && (r_state != ST_IDLE)) begin
         if (w_wrap) begin
            r_cnt <= '0;
            if (r_state == ST_BLINK)
               r_phase <= ~r_phase;
            if (r_state == ST_SCROLL)
               r_digits <= w_rot;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   // Walk from the top digit down so leading-zero runs can be tracked in one pass.
   always_comb begin
      hex     = '1;
      w_nib   = '0;
      w_blank = 1'b0;
`ifdef LZ_BLANK_EN
      w_lz_run = 1'b1;
`endif
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_nib   = r_digits[4*i +: 4];
         w_blank = (r_state == ST_IDLE) || ((r_state == ST_BLINK) && r_phase);
`ifdef LZ_BLANK_EN
         w_lz_run = w_lz_run && (w_nib == 4'h0);
         if ((i > 0) && w_lz_run)
            w_blank = 1'b1;
`endif
         hex[7*i +: 7] = w_blank ? 7'h7F : f_glyph(w_nib);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hex_display_bank.sv
// +--------------------------------------------------------------------------+
// | tb_hex_display_bank                                                      |
// | Directed bench for hex_display_bank with NUM_DIGITS=2, TICK_DIV=4.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hex_display_bank;

   logic        clk = 1'b0;
   logic        reset, load, enable;
   logic [7:0]  data;
   logic [1:0]  mode;
   logic [13:0] hex;
   logic        tick;

   int checks = 0;
   int errors = 0;

   localparam logic [13:0] c_blank = 14'h3FFF;
   localparam logic [13:0] c_12    = {7'h79, 7'h24};
   localparam logic [13:0] c_21    = {7'h24, 7'h79};
   localparam logic [13:0] c_55    = {7'h12, 7'h12};
`ifdef LZ_BLANK_EN
   localparam logic [6:0]  c_z     = 7'h7F;
`else
   localparam logic [6:0]  c_z     = 7'h40;
`endif

   typedef struct {
      logic [7:0]  data;
      logic [1:0]  mode;
      logic [13:0] exp;
   } vec_t;

   vec_t vecs[9];

   hex_display_bank #(
      .NUM_DIGITS (2),
      .TICK_DIV   (4)
   ) dut (
      .clock  (clk),
      .reset  (reset),
      .load   (load),
      .data   (data),
      .mode   (mode),
      .enable (enable),
      .hex    (hex),
      .tick   (tick)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{8'h3A, 2'b00, {7'h30, 7'h08}};
      vecs[1] = '{8'h05, 2'b00, {c_z,   7'h12}};
      vecs[2] = '{8'h00, 2'b00, {c_z,   7'h40}};
      vecs[3] = '{8'hF7, 2'b11, {7'h0E, 7'h78}};
      vecs[4] = '{8'h9B, 2'b00, {7'h10, 7'h03}};
      vecs[5] = '{8'hC4, 2'b00, {7'h46, 7'h19}};
      vecs[6] = '{8'hE6, 2'b01, {7'h06, 7'h02}};
      vecs[7] = '{8'hD8, 2'b10, {7'h21, 7'h00}};
      vecs[8] = '{8'h12, 2'b00, c_12};

      reset = 1'b1; load = 1'b0; data = '0; mode = '0; enable = 1'b0;
      cyc(); cyc();
      chk("reset_hex", 32'(hex), 32'(c_blank));
      chk("reset_tick", 32'(tick), 32'd0);

      // IDLE: no tick, still blank
      reset = 1'b0; enable = 1'b1;
      repeat (10) begin
         cyc();
         chk("idle_tick", 32'(tick), 32'd0);
      end
      chk("idle_hex", 32'(hex), 32'(c_blank));

      // Table of loads, prescaler frozen
      enable = 1'b0;
      for (int i = 0; i < 9; i++) begin
         load = 1'b1; data = vecs[i].data; mode = vecs[i].mode;
         cyc();
         load = 1'b0;
         chk($sformatf("vec%0d_hex", i), 32'(hex), 32'(vecs[i].exp));
      end

      // Static holds with the prescaler running
      enable = 1'b1;
      load = 1'b1; data = 8'h3A; mode = 2'b00;
      cyc(); load = 1'b0;
      repeat (20) cyc();
      chk("static_hold", 32'(hex), 32'({7'h30, 7'h08}));
      load = 1'b1; data = 8'hF7; mode = 2'b11;
      cyc(); load = 1'b0;
      repeat (9) cyc();
      chk("mode11_hold", 32'(hex), 32'({7'h0E, 7'h78}));

      // Blink
      load = 1'b1; data = 8'h12; mode = 2'b01;
      cyc(); load = 1'b0;
      for (int t = 0; t < 12; t++) begin
         chk($sformatf("blink_tick_t%0d", t), 32'(tick), 32'((t % 4) == 3));
         chk($sformatf("blink_hex_t%0d", t), 32'(hex), 32'(((t / 4) % 2) ? c_blank : c_12));
         cyc();
      end

      // Scroll, then freeze on the rotated pattern
      load = 1'b1; data = 8'h12; mode = 2'b10;
      cyc(); load = 1'b0;
      for (int t = 0; t < 6; t++) begin
         chk($sformatf("scroll_tick_t%0d", t), 32'(tick), 32'((t % 4) == 3));
         chk($sformatf("scroll_hex_t%0d", t), 32'(hex), 32'((t < 4) ? c_12 : c_21));
         if (t < 5) cyc();
      end
      enable = 1'b0;
      repeat (10) begin
         cyc();
         chk("freeze_hex", 32'(hex), 32'(c_21));
         chk("freeze_tick", 32'(tick), 32'd0);
      end
      enable = 1'b1;
      cyc(); cyc();
      chk("resume_tick", 32'(tick), 32'd1);
      cyc();
      chk("resume_hex", 32'(hex), 32'(c_12));

      // Load coinciding with tick wins over rotation
      cyc(); cyc(); cyc();
      chk("pre_load_tick", 32'(tick), 32'd1);
      load = 1'b1; data = 8'h55; mode = 2'b10;
      cyc(); load = 1'b0;
      chk("tickload55_hex", 32'(hex), 32'(c_55));
      chk("tickload55_tick", 32'(tick), 32'd0);
      cyc(); chk("restart_t1", 32'(tick), 32'd0);
      cyc(); chk("restart_t2", 32'(tick), 32'd0);
      cyc(); chk("restart_t3", 32'(tick), 32'd1);
      load = 1'b1; data = 8'h12; mode = 2'b10;
      cyc(); load = 1'b0;
      chk("tickload12_hex", 32'(hex), 32'(c_12));
      chk("tickload12_tick", 32'(tick), 32'd0);
      cyc(); cyc(); cyc();
      chk("tickload12_next_tick", 32'(tick), 32'd1);
      cyc();
      chk("tickload12_rot", 32'(hex), 32'(c_21));

      // Reset beats Load mid-scroll
      reset = 1'b1; load = 1'b1; data = 8'h34; mode = 2'b10;
      cyc();
      chk("rst_load_hex", 32'(hex), 32'(c_blank));
      chk("rst_load_tick", 32'(tick), 32'd0);
      reset = 1'b0; load = 1'b0;
      repeat (6) begin
         cyc();
         chk("post_rst_tick", 32'(tick), 32'd0);
      end
      chk("post_rst_hex", 32'(hex), 32'(c_blank));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
